// File: rtl/ctrl_pipe_reg.sv
// Multi-stage control-word pipeline register with stall, per-stage flush and invalid-input gating.
// Optional PIPE_CTRL_STATS_EN adds saturating stall/flush event counters.
module ctrl_pipe_reg #(
  parameter int                WIDTH  = 6,
  parameter int                STAGES = 1,
  parameter logic [WIDTH-1:0]  BUBBLE = {WIDTH{1'b0}}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             ctrl_in,
  input  logic                         valid_in,
  input  logic                         stall,
  input  logic [STAGES-1:0]            flush,
  output logic [WIDTH-1:0]             ctrl_out,
  output logic                         valid_out,
`ifdef PIPE_CTRL_STATS_EN
  output logic [15:0]                  stall_cnt,
  output logic [15:0]                  flush_cnt,
`endif
  output logic [$clog2(STAGES+1)-1:0]  occupancy
);

  localparam int OCC_W = $clog2(STAGES+1);

  generate
    if (STAGES < 1 || STAGES > 8) begin : gBadStages
      $error("ctrl_pipe_reg: STAGES must be in 1..8");
    end
  endgenerate

  logic [STAGES-1:0][WIDTH-1:0] ctrlPipe;
  logic [STAGES-1:0]            vldPipe;
  logic [STAGES-1:0][WIDTH-1:0] ctrlNext;
  logic [STAGES-1:0]            vldNext;

  // Invalid input is squashed to BUBBLE on entry so every v=0 stage holds BUBBLE.
  assign ctrlNext[0] = valid_in ? ctrl_in : BUBBLE;
  assign vldNext[0]  = valid_in;

  genvar g;
  generate
    for (g = 1; g < STAGES; g++) begin : gLink
      assign ctrlNext[g] = ctrlPipe[g-1];
      assign vldNext[g]  = vldPipe[g-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      if (rst || flush[k]) begin
        ctrlPipe[k] <= BUBBLE;
        vldPipe[k]  <= 1'b0;
      end else if (!stall) begin
        ctrlPipe[k] <= ctrlNext[k];
        vldPipe[k]  <= vldNext[k];
      end
    end
  end

  assign ctrl_out  = ctrlPipe[STAGES-1];
  assign valid_out = vldPipe[STAGES-1];

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < STAGES; k++)
      occupancy = occupancy + OCC_W'(vldPipe[k]);
  end

`ifdef PIPE_CTRL_STATS_EN
  logic [3:0]  flushHits;
  logic [16:0] flushSum;

  // Only flushes that actually kill a valid word are counted.
  always_comb begin
    flushHits = '0;
    for (int k = 0; k < STAGES; k++)
      flushHits = flushHits + 4'(flush[k] & vldPipe[k]);
  end

  assign flushSum = {1'b0, flush_cnt} + 17'(flushHits);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && occupancy != '0 && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      flush_cnt <= flushSum[16] ? 16'hFFFF : flushSum[15:0];
    end
  end
`endif

endmodule
